// File: rtl/button_debouncer.sv
// button_debouncer
//   Multi-channel debouncer and edge detector for already-synchronised button levels.
//   Each channel runs its own counter and 4-state FSM. A change is accepted only after
//   DEBOUNCE_CYCLES consecutive samples that differ from the current debounced level.
//   Accepted changes produce a one-cycle press or release strobe.
//
//   State table (per channel):
//     state        | meaning
//     IDLE         | debounced level 0, input agrees
//     PRESS_WAIT   | level 0, counting consecutive 1 samples
//     PRESSED      | debounced level 1, input agrees
//     RELEASE_WAIT | level 1, counting consecutive 0 samples
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_sync     synchronised raw levels, 1 = pressed
//   btn_level    debounced level per channel
//   btn_press    one-cycle strobe on accepted 0->1
//   btn_release  one-cycle strobe on accepted 1->0
//   any_press    registered OR of the press conditions, aligned with btn_press
module button_debouncer #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] btn_sync,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic                 any_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_BUTTONS-1:0] press_nxt;
  logic                 any_press_q;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // cnt_q never exceeds DEBOUNCE_CYCLES-1, so the increment cannot overflow CNT_W.
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_sync[g]) begin
            if (CNT_LAST == CNT_ONE) begin
              state_d = PRESSED;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync[g]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          if (!btn_sync[g]) begin
            if (CNT_LAST == CNT_ONE) begin
              state_d   = IDLE;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync[g]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign press_nxt[g]   = press_d;
  end

  // Built from the next-state press conditions so it lands in the same cycle as btn_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_nxt;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  localparam int N  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_sync = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         any_press;

  button_debouncer #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_sync   (btn_sync),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic         any;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: debounced level plus length of the current run of samples
  // that disagree with it. A run reaching DC flips the level.
  logic [N-1:0] m_lvl = '0;
  int           m_run[N];

  function automatic void model_reset();
    m_lvl = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endfunction

  function automatic exp_t model_step(input logic [N-1:0] v);
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i] != m_lvl[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DC) begin
          m_lvl[i] = v[i];
          m_run[i] = 0;
          if (v[i]) e.prs[i] = 1'b1;
          else      e.rel[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    e.lvl = m_lvl;
    e.any = |e.prs;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Called at posedge+3; drives a sample and queues the response expected after the next edge.
  task automatic step(input logic [N-1:0] v);
    btn_sync = v;
    @(posedge clk);
    exp_q.push_back(model_step(v));
    #3;
  endtask

  task automatic steps(input logic [N-1:0] v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  // Called at posedge+3; asserts reset mid-cycle and checks outputs fall without a clock.
  task automatic do_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_level",   {28'd0, btn_level},   32'd0);
    check("rst_press",   {28'd0, btn_press},   32'd0);
    check("rst_release", {28'd0, btn_release}, 32'd0);
    check("rst_any",     {31'd0, any_press},   32'd0);
    exp_q.delete();
    model_reset();
    repeat (hold) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    cycle++;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (btn_level !== mon_e.lvl || btn_press !== mon_e.prs ||
          btn_release !== mon_e.rel || any_press !== mon_e.any) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: got lvl=%b prs=%b rel=%b any=%b expected lvl=%b prs=%b rel=%b any=%b",
                 cycle, btn_level, btn_press, btn_release, any_press,
                 mon_e.lvl, mon_e.prs, mon_e.rel, mon_e.any);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  logic [N-1:0] rv;

  initial begin
    model_reset();
    #5;
    check("reset_level",   {28'd0, btn_level},   32'd0);
    check("reset_press",   {28'd0, btn_press},   32'd0);
    check("reset_release", {28'd0, btn_release}, 32'd0);
    check("reset_any",     {31'd0, any_press},   32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // clean press on ch0
    steps(4'b0001, 6);
    steps(4'b0000, 5);

    // glitch rejection on ch1, then bounce followed by a clean window
    steps(4'b0010, 3);
    steps(4'b0000, 2);
    step(4'b0010);
    step(4'b0000);
    steps(4'b0010, 5);

    // ch0 press, short dip, then real release
    steps(4'b0011, 4);
    steps(4'b0010, 2);
    step(4'b0011);
    steps(4'b0010, 5);
    steps(4'b0000, 5);

    // long hold on ch2
    steps(4'b0100, 20);
    steps(4'b0000, 5);

    // simultaneous ch0 + ch3
    steps(4'b1001, 5);
    steps(4'b0000, 5);

    // reset mid-window, then reset during a strobe
    steps(4'b0010, 2);
    do_reset(2);
    steps(4'b0010, 3);
    step(4'b0010);
    check("strobe_before_rst", {28'd0, btn_press}, 32'h2);
    check("any_before_rst",    {31'd0, any_press}, 32'h1);
    do_reset(1);
    steps(4'b0010, 6);
    steps(4'b0000, 5);

    // random bouncy traffic
    rv = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
      step(rv);
    end
    steps(4'b0000, 6);

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    #11;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
